alu_sequencer: RTL

Program sequencer for the accumulator ALU. It holds a small loadable program of (opcode, operand) pairs. On `start`, it issues one instruction per clock to the ALU's `control`/`in` ports, then captures the final accumulator and flags. It sits between the host and the ALU, so the host no longer hand-drives opcodes every cycle.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_seq_prog_mem.sv | 27 ++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the accumulator-ALU program sequencer: FSM states,
// program-word layout and the ALU opcodes the sequencer issues.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2
  } seq_state_e;

  // Program word is {opcode, operand}; operand sits at bit 0.
  localparam int OPC_W    = 3;
  localparam int OPND_LSB = 0;

  function automatic int opc_lsb(input int width);
    return OPND_LSB + width;
  endfunction

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_NEG   = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;
  localparam logic [2:0] OP_NOT   = 3'd5;
  localparam logic [2:0] OP_XOR   = 3'd6;
  localparam logic [2:0] OP_AND   = 3'd7;

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store for alu_sequencer: one synchronous write port, one
// asynchronous read port, deliberately without reset.
module alu_seq_prog_mem
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [OPC_W+WIDTH-1:0]     i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [OPC_W+WIDTH-1:0]     o_rdata
);

  localparam int WW = OPC_W + WIDTH;

  logic [WW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Issues a stored (opcode, operand) program to the accumulator ALU, one slot
// per clock, then captures the result. Optional macro: ALU_SEQ_OVF_ABORT_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int OVF_BIT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [OPC_W+WIDTH-1:0]     prog_data,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic [WIDTH-1:0]           result,
  output logic [3:0]                 result_flags,
  output logic [WIDTH-1:0]           alu_in,
  output logic [2:0]                 alu_control,
  input  logic [WIDTH-1:0]           alu_acc,
  input  logic [3:0]                 alu_flags
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int WW      = OPC_W + WIDTH;
  localparam int OPC_LSB = opc_lsb(WIDTH);

  seq_state_e        r_state;
  logic [AW-1:0]     r_pc;
  logic [LW-1:0]     r_len;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic [WIDTH-1:0]  r_result;
  logic [3:0]        r_flags;

  logic [WW-1:0]     w_word;
  logic [OPC_W-1:0]  w_opc;
  logic [WIDTH-1:0]  w_opnd;
  logic [LW-1:0]     w_len_clamped;
  logic              w_last;
  logic              w_ovf_flag;
  logic              w_ovf_stop;
  logic              w_mem_we;

  assign w_mem_we = prog_we && (r_state == ST_IDLE);

  alu_seq_prog_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (r_pc),
    .o_rdata (w_word)
  );

  assign w_opc         = w_word[OPC_LSB +: OPC_W];
  assign w_opnd        = w_word[OPND_LSB +: WIDTH];
  assign w_len_clamped = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
  assign w_last        = ({1'b0, r_pc} == (r_len - LW'(1)));
  assign w_ovf_flag    = alu_flags[OVF_BIT];

`ifdef ALU_SEQ_OVF_ABORT_EN
  // Flags lag the issue by one cycle, so slot 0 can never be the one stopped.
  assign w_ovf_stop = (r_state == ST_RUN) && (r_pc != '0) && w_ovf_flag;
`else
  assign w_ovf_stop = w_ovf_flag & 1'b0;
`endif

  always_comb begin
    alu_control = OP_HOLD;
    alu_in      = '0;
    if ((r_state == ST_RUN) && !w_ovf_stop) begin
      alu_control = w_opc;
      alu_in      = w_opnd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_len     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_result  <= '0;
      r_flags   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy    <= 1'b1;
            r_aborted <= 1'b0;
            r_pc      <= '0;
            if (w_len_clamped == '0) begin
              r_state <= ST_CAPTURE;
            end else begin
              r_len   <= w_len_clamped;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_ovf_stop) begin
`ifdef ALU_SEQ_OVF_ABORT_EN
            r_aborted <= 1'b1;
`endif
            r_state <= ST_CAPTURE;
          end else if (w_last) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_pc <= r_pc + AW'(1);
          end
        end
        ST_CAPTURE: begin
          r_result <= alu_acc;
          r_flags  <= alu_flags;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign result       = r_result;
  assign result_flags = r_flags;

endmodule
